// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the Booth multiplier controller and its datapath:
//   state_e        controller FSM states
//   CTRL_*         2-bit datapath command codes
//   clog2()        ceiling log2 used to size iteration counters
package booth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_EVAL  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_CAPT  = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   // Datapath commands
   localparam logic [1:0] CTRL_INIT  = 2'b00; // load operands, clear X and counter
   localparam logic [1:0] CTRL_ADD   = 2'b01; // X += A
   localparam logic [1:0] CTRL_SUB   = 2'b10; // X -= A
   localparam logic [1:0] CTRL_SHIFT = 2'b11; // arithmetic right shift of {X,B}

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/booth_dp.sv
// booth_dp
// Booth radix-2 datapath: N-bit accumulator X, multiplicand register A,
// multiplier/low-product register B, and a shift counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ctrl        command (CTRL_INIT / CTRL_ADD / CTRL_SUB / CTRL_SHIFT)
//   a, b        operands, loaded on CTRL_INIT
//   out         {X,B}, the running / final product
//   status      [1] = B[0], [0] = shift counter reached BIT_LEN
module booth_dp
   import booth_pkg::*;
#(
   parameter int BIT_LEN = 4
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           ctrl,
   input  logic [BIT_LEN-1:0]   a,
   input  logic [BIT_LEN-1:0]   b,
   output logic [2*BIT_LEN-1:0] out,
   output logic [1:0]           status
);

   localparam int CW = clog2(BIT_LEN) + 1;

   logic [BIT_LEN-1:0] a_q, a_d;
   logic [BIT_LEN-1:0] b_q, b_d;
   logic [BIT_LEN-1:0] x_q, x_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      x_d   = x_q;
      cnt_d = cnt_q;
      case (ctrl)
         CTRL_INIT: begin
            a_d   = a;
            b_d   = b;
            x_d   = '0;
            cnt_d = '0;
         end
         CTRL_ADD: x_d = x_q + a_q;
         CTRL_SUB: x_d = x_q - a_q;
         default: begin
            // Arithmetic shift: X's sign bit is replicated into the top.
            {x_d, b_d} = {x_q[BIT_LEN-1], x_q, b_q[BIT_LEN-1:1]};
            cnt_d      = cnt_q + CW'(1);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         x_q   <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         x_q   <= x_d;
         cnt_q <= cnt_d;
      end
   end

   assign out    = {x_q, b_q};
   assign status = {b_q[0], (cnt_q == CW'(BIT_LEN))};

endmodule

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl
// Sequencer for a radix-2 Booth multiplier. Accepts a pair of signed
// operands, steps the datapath through N evaluate/shift iterations and
// presents the signed 2N-bit product.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, ready         request handshake; accepted when both are high
//   a_in, b_in           signed multiplicand / multiplier
//   abort                cancel the operation in flight (LOAD..CAPT)
//   busy                 high in LOAD, EVAL, SHIFT, CAPT
//   res_valid, res_ready result handshake
//   product              signed product, held stable while res_valid
//   res_ovf              product invalid: a is the most negative value, b != 0
//
// Handshakes: a transfer happens on a rising edge where valid (start or
// res_valid) and ready (ready or res_ready) are both high. Once res_valid
// rises, product and res_ovf hold until that transfer completes.
module booth_mul_ctrl
   import booth_pkg::*;
#(
   parameter int BIT_LEN = 4
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_LEN-1:0]   a_in,
   input  logic [BIT_LEN-1:0]   b_in,
   output logic                 ready,
   input  logic                 abort,
   output logic                 busy,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*BIT_LEN-1:0] product,
   output logic                 res_ovf
);

   localparam int IW = clog2(BIT_LEN) + 1;
   localparam logic [BIT_LEN-1:0] A_MIN = {1'b1, {(BIT_LEN-1){1'b0}}};

   state_e                 state_q, state_d;
   logic [IW-1:0]          it_q, it_d;
   logic                   q_prev_q, q_prev_d;
   logic [BIT_LEN-1:0]     op_a_q, op_a_d;
   logic [BIT_LEN-1:0]     op_b_q, op_b_d;
   logic [2*BIT_LEN-1:0]   product_q, product_d;
   logic                   res_ovf_q, res_ovf_d;

   logic [1:0]             dp_ctrl;
   logic [2*BIT_LEN-1:0]   dp_out;
   logic [1:0]             dp_status;
   logic                   dp_b0;
   logic                   dp_cnt_done_unused;
   logic                   dp_rst_n;
   logic                   shift_issued;

   assign dp_rst_n           = ~rst;
   assign dp_b0              = dp_status[1];
   // Termination is decided by it_q; the datapath's own counter is not used.
   assign dp_cnt_done_unused = dp_status[0];

   booth_dp #(.BIT_LEN(BIT_LEN)) u_dp (
      .clk    (clk),
      .rst_n  (dp_rst_n),
      .ctrl   (dp_ctrl),
      .a      (op_a_q),
      .b      (op_b_q),
      .out    (dp_out),
      .status (dp_status)
   );

   always_comb begin
      state_d      = state_q;
      it_d         = it_q;
      q_prev_d     = q_prev_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      product_d    = product_q;
      res_ovf_d    = res_ovf_q;
      dp_ctrl      = CTRL_INIT;
      shift_issued = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_a_d  = a_in;
               op_b_d  = b_in;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            it_d     = '0;
            q_prev_d = 1'b0;
            state_d  = ST_EVAL;
         end
         ST_EVAL: begin
            case ({dp_b0, q_prev_q})
               2'b10: begin
                  dp_ctrl = CTRL_SUB;
                  state_d = ST_SHIFT;
               end
               2'b01: begin
                  dp_ctrl = CTRL_ADD;
                  state_d = ST_SHIFT;
               end
               default: begin
                  // No add/sub needed: this shift is the iteration's shift.
                  dp_ctrl      = CTRL_SHIFT;
                  shift_issued = 1'b1;
               end
            endcase
         end
         ST_SHIFT: begin
            dp_ctrl      = CTRL_SHIFT;
            shift_issued = 1'b1;
         end
         ST_CAPT: begin
            product_d = dp_out;
            res_ovf_d = (op_a_q == A_MIN) && (op_b_q != '0);
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (shift_issued) begin
         q_prev_d = dp_b0;
         it_d     = it_q + IW'(1);
         state_d  = (it_q == IW'(BIT_LEN - 1)) ? ST_CAPT : ST_EVAL;
      end

      // Abort wins over everything in the working states, including the
      // final shift and the capture edge; the previous result is kept.
      if (abort && (state_q == ST_LOAD || state_q == ST_EVAL ||
                    state_q == ST_SHIFT || state_q == ST_CAPT)) begin
         state_d   = ST_IDLE;
         product_d = product_q;
         res_ovf_d = res_ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         it_q      <= '0;
         q_prev_q  <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         product_q <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         it_q      <= it_d;
         q_prev_q  <= q_prev_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         product_q <= product_d;
         res_ovf_q <= res_ovf_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_EVAL) ||
                      (state_q == ST_SHIFT) || (state_q == ST_CAPT);
   assign res_valid = (state_q == ST_RESP);
   assign product   = product_q;
   assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl
// Self-checking bench for booth_mul_ctrl with BIT_LEN=4: directed vectors,
// randomized operands/back-pressure against an arithmetic reference model,
// abort, back-pressure hold and mid-operation reset.
module tb_booth_mul_ctrl;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic           res_ready = 1'b1;
   logic [N-1:0]   a_in = '0;
   logic [N-1:0]   b_in = '0;
   logic           ready, busy, res_valid, res_ovf;
   logic [2*N-1:0] product;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard entries are {ovf, product}
   logic [2*N:0] exp_q[$];

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] p;
      logic           o;
      int             lat;
   } vec_t;

   booth_mul_ctrl #(.BIT_LEN(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .ready     (ready),
      .abort     (abort),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .product   (product),
      .res_ovf   (res_ovf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Product by plain arithmetic; latency from the Booth recoding rule:
   // one extra cycle per bit of b that differs from the bit below it.
   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [2*N-1:0] p, output logic o,
                                 output int lat);
      int sa, sb, prod, k;
      logic prev;
      sa   = $signed(a);
      sb   = $signed(b);
      prod = sa * sb;
      p    = prod[2*N-1:0];
      o    = (sa == -(1 << (N-1))) && (sb != 0);
      k    = N;
      prev = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (b[i] != prev) k++;
         prev = b[i];
      end
      lat = k + 3;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL launch_ready: got ready=%0b expected 1 within 40 cycles", ready);
      end
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = N'($urandom_range(0, 15));
      b_in  = N'($urandom_range(0, 15));
   endtask

   // Cycle 1 is the cycle right after the accepting edge.
   task automatic collect(output bit got, output int lat,
                          output logic [2*N-1:0] p, output logic o);
      got = 1'b0;
      lat = 0;
      p   = '0;
      o   = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            got = 1'b1;
            lat = c;
            p   = product;
            o   = res_ovf;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ready, busy, res_valid, res_ovf} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_flags: got {ready,busy,valid,ovf}=%b expected 1000",
                  {ready, busy, res_valid, res_ovf});
      end
      n_cmp++;
      if (product !== '0) begin
         n_err++;
         $display("FAIL reset_product: got %h expected 00", product);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ready, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL post_reset_idle: got {ready,busy}=%b expected 10", {ready, busy});
      end
   endtask

   task automatic test_directed();
      vec_t           tv [5];
      logic [2*N:0]   e;
      logic [2*N-1:0] p;
      logic           o;
      int             lat;
      bit             got;
      tv[0] = '{4'd3,  4'hE, 8'hFA, 1'b0, 8};
      tv[1] = '{4'd5,  4'h5, 8'h19, 1'b0, 11};
      tv[2] = '{4'd0,  4'h0, 8'h00, 1'b0, 7};
      tv[3] = '{4'h8,  4'h1, 8'h00, 1'b1, 9};
      tv[4] = '{4'h8,  4'h0, 8'h00, 1'b0, 7};
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({tv[i].o, tv[i].p});
         launch(tv[i].a, tv[i].b);
         collect(got, lat, p, o);
         e = exp_q.pop_front();
         n_cmp++;
         if (!got) begin
            n_err++;
            $display("FAIL dir%0d_timeout: res_valid never rose, expected in cycle %0d", i, tv[i].lat);
            continue;
         end
         if (lat != tv[i].lat) begin
            n_err++;
            $display("FAIL dir%0d_latency: got cycle %0d expected %0d", i, lat, tv[i].lat);
         end
         n_cmp++;
         if (o !== e[2*N]) begin
            n_err++;
            $display("FAIL dir%0d_ovf: got %0b expected %0b", i, o, e[2*N]);
         end
         if (!e[2*N]) begin
            n_cmp++;
            if (p !== e[2*N-1:0]) begin
               n_err++;
               $display("FAIL dir%0d_product: got %h expected %h", i, p, e[2*N-1:0]);
            end
         end
         @(negedge clk);
         n_cmp++;
         if ({ready, res_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL dir%0d_return_idle: got {ready,valid}=%b expected 10", i, {ready, res_valid});
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0]   a, b;
      logic [2*N-1:0] ep, p;
      logic           eo, o;
      logic [2*N:0]   e;
      int             elat, lat, d;
      bit             got;
      for (int i = 0; i < 40; i++) begin
         a = N'($urandom_range(0, 15));
         b = N'($urandom_range(0, 15));
         d = $urandom_range(0, 3);
         model(a, b, ep, eo, elat);
         exp_q.push_back({eo, ep});
         res_ready = (d == 0);
         launch(a, b);
         collect(got, lat, p, o);
         e = exp_q.pop_front();
         n_cmp++;
         if (!got) begin
            n_err++;
            $display("FAIL rnd%0d_timeout: a=%h b=%h no res_valid", i, a, b);
            res_ready = 1'b1;
            continue;
         end
         if (lat != elat) begin
            n_err++;
            $display("FAIL rnd%0d_latency: a=%h b=%h got %0d expected %0d", i, a, b, lat, elat);
         end
         n_cmp++;
         if (o !== e[2*N]) begin
            n_err++;
            $display("FAIL rnd%0d_ovf: a=%h b=%h got %0b expected %0b", i, a, b, o, e[2*N]);
         end
         if (!e[2*N]) begin
            n_cmp++;
            if (p !== e[2*N-1:0]) begin
               n_err++;
               $display("FAIL rnd%0d_product: a=%h b=%h got %h expected %h", i, a, b, p, e[2*N-1:0]);
            end
         end
         if (d > 0) begin
            repeat (d) @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b1 || product !== p) begin
               n_err++;
               $display("FAIL rnd%0d_hold: got valid=%0b product=%h expected 1 and %h", i, res_valid, product, p);
            end
         end
         res_ready = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL rnd%0d_ready_after: got %0b expected 1", i, ready);
         end
      end
   endtask

   // Aborted runs must leave the last completed product (8'hFA) in place.
   task automatic test_abort();
      logic [2*N-1:0] p;
      logic           o;
      int             lat;
      bit             got;
      int             abort_cycle [3];
      logic [N-1:0]   ab_a [3];
      logic [N-1:0]   ab_b [3];
      res_ready = 1'b1;
      launch(4'd3, 4'hE);
      collect(got, lat, p, o);
      n_cmp++;
      if (!got || p !== 8'hFA) begin
         n_err++;
         $display("FAIL abort_setup: got valid=%0b product=%h expected 1 and fa", got, p);
      end
      // 7*7 aborted in cycle 4 (EVAL/SHIFT); 3*0 aborted on its final shift
      // (cycle 5) and in CAPT (cycle 6).
      abort_cycle[0] = 4; ab_a[0] = 4'd7; ab_b[0] = 4'd7;
      abort_cycle[1] = 5; ab_a[1] = 4'd3; ab_b[1] = 4'd0;
      abort_cycle[2] = 6; ab_a[2] = 4'd3; ab_b[2] = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         launch(ab_a[i], ab_b[i]);
         got = 1'b0;
         for (int c = 1; c < abort_cycle[i]; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) got = 1'b1;
         end
         @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         n_cmp++;
         if (got || {ready, busy, res_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL abort%0d_idle: got early_valid=%0b {ready,busy,valid}=%b expected 0 and 100",
                     i, got, {ready, busy, res_valid});
         end
         n_cmp++;
         if (product !== 8'hFA || res_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL abort%0d_product_kept: got %h ovf=%0b expected fa ovf=0", i, product, res_ovf);
         end
      end
      // Abort held high in IDLE is ignored: the start is still accepted.
      abort = 1'b1;
      launch(4'h9, 4'd7);
      abort = 1'b0;
      collect(got, lat, p, o);
      n_cmp++;
      if (!got || p !== 8'hCF || o !== 1'b0 || lat != 9) begin
         n_err++;
         $display("FAIL abort_then_start: got valid=%0b product=%h ovf=%0b cycle=%0d expected 1 cf 0 9",
                  got, p, o, lat);
      end
   endtask

   task automatic test_backpressure();
      logic [2*N-1:0] p;
      logic           o;
      int             lat;
      bit             got;
      @(negedge clk);
      res_ready = 1'b0;
      launch(4'd2, 4'd3);
      collect(got, lat, p, o);
      n_cmp++;
      if (!got || p !== 8'h06) begin
         n_err++;
         $display("FAIL bp_result: got valid=%0b product=%h expected 1 and 06", got, p);
      end
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         a_in  = N'($urandom_range(0, 15));
         b_in  = N'($urandom_range(0, 15));
         abort = (i == 2);
         @(negedge clk);
         n_cmp++;
         if ({res_valid, ready, busy} !== 3'b100 || product !== 8'h06) begin
            n_err++;
            $display("FAIL bp_hold%0d: got {valid,ready,busy}=%b product=%h expected 100 and 06",
                     i, {res_valid, ready, busy}, product);
         end
      end
      start     = 1'b0;
      abort     = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ready, busy, res_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL bp_release: got {ready,busy,valid}=%b expected 100", {ready, busy, res_valid});
      end
   endtask

   task automatic test_rst_mid();
      logic [2*N-1:0] p;
      logic           o;
      int             lat;
      bit             got;
      res_ready = 1'b1;
      launch(4'd5, 4'd5);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ready, busy, res_valid, res_ovf} !== 4'b1000 || product !== '0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got {ready,busy,valid,ovf}=%b product=%h expected 1000 and 00",
                  {ready, busy, res_valid, res_ovf}, product);
      end
      @(negedge clk);
      rst = 1'b0;
      launch(4'd3, 4'hE);
      collect(got, lat, p, o);
      n_cmp++;
      if (!got || p !== 8'hFA || o !== 1'b0 || lat != 8) begin
         n_err++;
         $display("FAIL rst_mid_restart: got valid=%0b product=%h ovf=%0b cycle=%0d expected 1 fa 0 8",
                  got, p, o, lat);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_backpressure();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
